// File: rtl/pdec_reg_cmd_mst.sv
// Register-bus initiator for the pdec control register files.
// Runs write, read and poll commands one at a time and returns one response per command.
module pdec_reg_cmd_mst #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    input  logic [DW-1:0] cmd_mask,
    input  logic [TW-1:0] cmd_retry,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          busy,
    output logic          wen,
    output logic          ren,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] raddr,
    output logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StRdWait,
        StPollRd,
        StPollWait,
        StRsp
    } state_e;

    state_e        state;
    logic [DW-1:0] data_q;
    logic [DW-1:0] mask_q;
    logic [TW-1:0] cnt_q;

    logic poll_match;
    assign poll_match = ((rdata ^ data_q) & mask_q) == '0;

    // Every output is a register updated alongside the state, so each strobe
    // is high exactly while the FSM sits in the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            wen       <= 1'b0;
            ren       <= 1'b0;
            waddr     <= '0;
            raddr     <= '0;
            wdata     <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
        end else begin
            wen <= 1'b0;
            ren <= 1'b0;
            case (state)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        data_q    <= cmd_data;
                        mask_q    <= cmd_mask;
                        cnt_q     <= cmd_retry;
                        case (cmd_op)
                            2'd0: begin
                                state <= StWr;
                                wen   <= 1'b1;
                                waddr <= cmd_addr;
                                wdata <= cmd_data;
                            end
                            2'd1: begin
                                state <= StRd;
                                ren   <= 1'b1;
                                raddr <= cmd_addr;
                            end
                            2'd2: begin
                                state <= StPollRd;
                                ren   <= 1'b1;
                                raddr <= cmd_addr;
                            end
                            default: begin
                                state     <= StRsp;
                                rsp_valid <= 1'b1;
                                rsp_data  <= '0;
                                rsp_err   <= 1'b1;
                            end
                        endcase
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                StWr: begin
                    state     <= StRsp;
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                    rsp_err   <= 1'b0;
                end
                StRd: begin
                    state <= StRdWait;
                end
                StRdWait: begin
                    state     <= StRsp;
                    rsp_valid <= 1'b1;
                    rsp_data  <= rdata;
                    rsp_err   <= 1'b0;
                end
                StPollRd: begin
                    state <= StPollWait;
                end
                StPollWait: begin
                    rsp_data <= rdata;
                    if (poll_match) begin
                        state     <= StRsp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state     <= StRsp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - TW'(1);
                        state <= StPollRd;
                        ren   <= 1'b1;
                    end
                end
                StRsp: begin
                    if (rsp_ready) begin
                        state     <= StIdle;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= StIdle;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdec_reg_cmd_mst.sv
// Bench for pdec_reg_cmd_mst: a transaction-level model predicts every output each cycle,
// and directed commands carry hand-computed latency/data expectations.
module tb_pdec_reg_cmd_mst;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [DW-1:0] cmd_mask = '0;
    logic [TW-1:0] cmd_retry = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;
    logic          wen;
    logic          ren;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata = '0;

    always #5 clk = ~clk;

    pdec_reg_cmd_mst #(.AW(AW), .DW(DW), .TW(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_mask  (cmd_mask),
        .cmd_retry (cmd_retry),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .wen       (wen),
        .ren       (ren),
        .waddr     (waddr),
        .raddr     (raddr),
        .wdata     (wdata),
        .rdata     (rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Register slave: returns the value for the n-th read of the current command.
    int            slave_mode = 0;
    logic [31:0]   slave_base = '0;
    int            nrd = 0;

    function automatic logic [31:0] slave_val(input int mode, input int n, input logic [31:0] base);
        case (mode)
            1:       return base | ((n >= 3) ? 32'h1 : 32'h0);
            2:       return base + 32'(n);
            default: return base;
        endcase
    endfunction

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready && !rst) begin
            nrd <= 0;
        end else if (ren) begin
            rdata <= slave_val(slave_mode, nrd + 1, slave_base);
            nrd   <= nrd + 1;
        end
    end

    // Model: one command in flight; rel counts cycles after the accepting edge.
    bit          active = 1'b0;
    bit          prev_rst = 1'b1;
    int          rel = 0;
    int          rsp_cyc = 0;
    int          k = 0;
    logic [1:0]  m_op = '0;
    logic [31:0] e_data = '0;
    bit          e_err = 1'b0;
    logic [31:0] e_waddr = '0;
    logic [31:0] e_wdata = '0;
    logic [31:0] e_raddr = '0;
    logic        e_wen, e_ren, e_vld, e_busy, e_rdy;

    int          first_valid = 0;
    int          ren_cnt = 0;
    int          wen_cnt = 0;
    int          done_cnt = 0;
    int          last_lat = 0;
    int          last_ren = 0;
    int          last_wen = 0;
    logic [31:0] last_data = '0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        if (active) rel++;
        if (prev_rst) begin
            e_wen = 1'b0; e_ren = 1'b0; e_vld = 1'b0; e_busy = 1'b0; e_rdy = 1'b0;
            check("rst_rsp_data", rsp_data, 32'h0);
            check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        end else if (active) begin
            e_wen  = (m_op == 2'd0) && (rel == 1);
            e_ren  = ((m_op == 2'd1) && (rel == 1)) ||
                     ((m_op == 2'd2) && (rel % 2 == 1) && (rel < 2 * k));
            e_vld  = rel >= rsp_cyc;
            e_busy = 1'b1;
            e_rdy  = 1'b0;
        end else begin
            e_wen = 1'b0; e_ren = 1'b0; e_vld = 1'b0; e_busy = 1'b0; e_rdy = 1'b1;
        end
        check("wen", {31'b0, wen}, {31'b0, e_wen});
        check("ren", {31'b0, ren}, {31'b0, e_ren});
        check("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_vld});
        check("busy", {31'b0, busy}, {31'b0, e_busy});
        check("cmd_ready", {31'b0, cmd_ready}, {31'b0, e_rdy});
        check("waddr", waddr, e_waddr);
        check("wdata", wdata, e_wdata);
        check("raddr", raddr, e_raddr);
        if (e_vld) begin
            check("rsp_data", rsp_data, e_data);
            check("rsp_err", {31'b0, rsp_err}, {31'b0, e_err});
        end

        if (active && ren) ren_cnt++;
        if (active && wen) wen_cnt++;
        if (active && rsp_valid && first_valid == 0) first_valid = rel;

        if (rst) begin
            active   = 1'b0;
            e_waddr  = '0;
            e_wdata  = '0;
            e_raddr  = '0;
            prev_rst = 1'b1;
        end else begin
            prev_rst = 1'b0;
            if (active && rel >= rsp_cyc && rsp_ready) begin
                active    = 1'b0;
                last_lat  = first_valid;
                last_ren  = ren_cnt;
                last_wen  = wen_cnt;
                last_data = rsp_data;
                last_err  = rsp_err;
                done_cnt++;
            end else if (!active && cmd_valid && cmd_ready) begin
                active      = 1'b1;
                rel         = 0;
                m_op        = cmd_op;
                first_valid = 0;
                ren_cnt     = 0;
                wen_cnt     = 0;
                case (cmd_op)
                    2'd0: begin
                        rsp_cyc = 2; k = 0; e_data = '0; e_err = 1'b0;
                        e_waddr = cmd_addr; e_wdata = cmd_data;
                    end
                    2'd1: begin
                        rsp_cyc = 3; k = 1; e_err = 1'b0;
                        e_data  = slave_val(slave_mode, 1, slave_base);
                        e_raddr = cmd_addr;
                    end
                    2'd2: begin
                        e_raddr = cmd_addr; e_err = 1'b1; k = 0;
                        for (int i = 1; i <= int'(cmd_retry) + 1; i++) begin
                            e_data = slave_val(slave_mode, i, slave_base);
                            k = i;
                            if (((e_data ^ cmd_data) & cmd_mask) == '0) begin
                                e_err = 1'b0;
                                break;
                            end
                        end
                        rsp_cyc = 2 * k + 1;
                    end
                    default: begin
                        rsp_cyc = 1; k = 0; e_data = '0; e_err = 1'b1;
                    end
                endcase
            end
        end
    end

    // Drivers act 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] mask, input logic [15:0] retry);
        int t = 0;
        while (cmd_ready !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) timeout("cmd_ready_wait");
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_mask  = mask;
        cmd_retry = retry;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int stall, input int d0);
        int t = 0;
        while (rsp_valid !== 1'b1 && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) timeout("rsp_valid_wait");
        for (int i = 0; i < stall; i++) step();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        check("done_count", done_cnt, d0 + 1);
    endtask

    task automatic expect_last(input string name, input int lat, input int nren, input int nwen,
                               input logic [31:0] data, input logic err);
        check({name, "_latency"}, last_lat, lat);
        check({name, "_ren_pulses"}, last_ren, nren);
        check({name, "_wen_pulses"}, last_wen, nwen);
        check({name, "_data"}, last_data, data);
        check({name, "_err"}, {31'b0, last_err}, {31'b0, err});
    endtask

    int d0;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        step();

        // Write with rsp_ready already high.
        d0 = done_cnt;
        rsp_ready = 1'b1;
        send(2'd0, 32'h8, 32'h3F, 32'h0, 16'd0);
        wait_rsp(0, d0);
        expect_last("write", 2, 0, 1, 32'h0, 1'b0);

        // Read stalled 4 cycles; a competing command waits while busy.
        d0 = done_cnt;
        slave_mode = 0; slave_base = 32'h1234_0000;
        send(2'd1, 32'h0, 32'h0, 32'h0, 16'd0);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 32'h44; cmd_data = 32'hBAD;
        wait_rsp(4, d0);
        expect_last("read", 3, 1, 0, 32'h1234_0000, 1'b0);

        // Poll matching on the 3rd read.
        d0 = done_cnt;
        slave_mode = 1; slave_base = 32'h0;
        send(2'd2, 32'h14, 32'h1, 32'h1, 16'd5);
        wait_rsp(0, d0);
        expect_last("poll_match3", 7, 3, 0, 32'h1, 1'b0);

        // Poll that never matches, retry 2.
        d0 = done_cnt;
        slave_mode = 0; slave_base = 32'h0;
        send(2'd2, 32'h14, 32'h1, 32'h1, 16'd2);
        wait_rsp(1, d0);
        expect_last("poll_timeout", 7, 3, 0, 32'h0, 1'b1);

        // Illegal op.
        d0 = done_cnt;
        send(2'd3, 32'h30, 32'h77, 32'hFF, 16'd3);
        wait_rsp(2, d0);
        expect_last("illegal", 1, 0, 0, 32'h0, 1'b1);

        // Mask 0 matches on the first read.
        d0 = done_cnt;
        slave_mode = 0; slave_base = 32'hDEAD_0000;
        send(2'd2, 32'h18, 32'h55, 32'h0, 16'd7);
        wait_rsp(0, d0);
        expect_last("poll_mask0", 3, 1, 0, 32'hDEAD_0000, 1'b0);

        // Retry 0, no match: a single read then timeout.
        d0 = done_cnt;
        slave_mode = 0; slave_base = 32'h10;
        send(2'd2, 32'h1C, 32'h1, 32'h1, 16'd0);
        wait_rsp(0, d0);
        expect_last("poll_retry0", 3, 1, 0, 32'h10, 1'b0 ^ 1'b1);

        // Multi-bit mask, match on the 4th read (0x101,0x102,0x103,0x104).
        d0 = done_cnt;
        slave_mode = 2; slave_base = 32'h100;
        send(2'd2, 32'h24, 32'h04, 32'hFF, 16'd9);
        wait_rsp(0, d0);
        expect_last("poll_mask_ff", 9, 4, 0, 32'h104, 1'b0);

        // Reset while in POLL_WAIT: command dropped, no response.
        d0 = done_cnt;
        slave_mode = 0; slave_base = 32'h0;
        send(2'd2, 32'h14, 32'h1, 32'h1, 16'd5);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (6) step();
        check("rst_no_response", done_cnt, d0);

        // A read after the reset completes normally.
        d0 = done_cnt;
        slave_mode = 0; slave_base = 32'hCAFE_F00D;
        send(2'd1, 32'h20, 32'h0, 32'h0, 16'd0);
        wait_rsp(0, d0);
        expect_last("read_after_rst", 3, 1, 0, 32'hCAFE_F00D, 1'b0);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
